// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: unit select codes, FSM states,
// the request function layout and the default result width.
package alu_pkg;

  localparam int unsigned DEF_OUT_WIDTH = 16;
  localparam int unsigned NUM_UNITS     = 4;

  typedef enum logic [1:0] {
    ARITH = 2'b00,
    LOGIC = 2'b01,
    CMP   = 2'b10,
    SHIFT = 2'b11
  } unit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  // req_FUNC layout: unit select on top, unit-local function below
  typedef struct packed {
    unit_t      unit;
    logic [1:0] op;
  } func_t;

  function automatic logic [NUM_UNITS-1:0] unit_onehot(input unit_t u);
    return NUM_UNITS'(1) << u;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response channels plus the shared operand bus to the four ALU units.
interface alu_ctrl_seq_if #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH = alu_pkg::DEF_OUT_WIDTH
);

  logic                 req_valid;
  logic                 req_ready;
  logic [A_WIDTH-1:0]   req_A;
  logic [B_WIDTH-1:0]   req_B;
  logic [3:0]           req_FUNC;

  logic [A_WIDTH-1:0]   A;
  logic [B_WIDTH-1:0]   B;
  logic [1:0]           ALU_FUNC;
  logic                 Arith_EN;
  logic                 Logic_EN;
  logic                 CMP_EN;
  logic                 SHIFT_EN;
  logic [OUT_WIDTH-1:0] Arith_OUT;
  logic [OUT_WIDTH-1:0] Logic_OUT;
  logic [OUT_WIDTH-1:0] CMP_OUT;
  logic [OUT_WIDTH-1:0] SHIFT_OUT;
  logic                 Arith_Flag;
  logic                 Logic_Flag;
  logic                 CMP_Flag;
  logic                 SHIFT_Flag;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_WIDTH-1:0] rsp_data;
  logic [1:0]           rsp_unit;
  logic                 rsp_err;

  // Sequencer side
  modport master (
    input  req_valid, req_A, req_B, req_FUNC, rsp_ready,
    input  Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT,
    input  Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag,
    output req_ready, A, B, ALU_FUNC,
    output Arith_EN, Logic_EN, CMP_EN, SHIFT_EN,
    output rsp_valid, rsp_data, rsp_unit, rsp_err
  );

  // Controller and unit side
  modport slave (
    output req_valid, req_A, req_B, req_FUNC, rsp_ready,
    output Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT,
    output Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag,
    input  req_ready, A, B, ALU_FUNC,
    input  Arith_EN, Logic_EN, CMP_EN, SHIFT_EN,
    input  rsp_valid, rsp_data, rsp_unit, rsp_err
  );

endinterface

// File: rtl/alu_seq_timeout.sv
// WAIT-cycle counter: cleared on issue, counts missing-flag cycles, and
// term_c flags the cycle whose increment brings the count to TIMEOUT.
module alu_seq_timeout #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic term_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign term_c = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_ctrl_seq.sv
// Command sequencer for the four registered ALU units: issues one request,
// waits for the selected unit's flag (or times out) and returns the result.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned TIMEOUT   = 4
) (
  input logic            CLK,
  input logic            RST,
  alu_ctrl_seq_if.master bus
);

  state_t                state, state_nxt;
  logic [A_WIDTH-1:0]    a_q, a_nxt;
  logic [B_WIDTH-1:0]    b_q, b_nxt;
  func_t                 func_q, func_nxt;
  logic [NUM_UNITS-1:0]  en_q, en_nxt;
  logic                  ready_q, ready_nxt;
  logic                  rsp_valid_q, rsp_valid_nxt;
  logic [OUT_WIDTH-1:0]  rsp_data_q, rsp_data_nxt;
  unit_t                 rsp_unit_q, rsp_unit_nxt;
  logic                  rsp_err_q, rsp_err_nxt;

  logic                  sel_flag_c;
  logic [OUT_WIDTH-1:0]  sel_out_c;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  cnt_term_c;

  alu_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (CLK),
    .rst_n  (RST),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .term_c (cnt_term_c)
  );

  // Only the selected unit's flag and result are ever looked at
  always_comb begin
    sel_flag_c = 1'b0;
    sel_out_c  = '0;
    case (func_q.unit)
      ARITH: begin sel_flag_c = bus.Arith_Flag; sel_out_c = bus.Arith_OUT; end
      LOGIC: begin sel_flag_c = bus.Logic_Flag; sel_out_c = bus.Logic_OUT; end
      CMP:   begin sel_flag_c = bus.CMP_Flag;   sel_out_c = bus.CMP_OUT;   end
      SHIFT: begin sel_flag_c = bus.SHIFT_Flag; sel_out_c = bus.SHIFT_OUT; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and next values of every registered output
  always_comb begin
    state_nxt     = state;
    a_nxt         = a_q;
    b_nxt         = b_q;
    func_nxt      = func_q;
    en_nxt        = '0;
    ready_nxt     = 1'b0;
    rsp_valid_nxt = rsp_valid_q;
    rsp_data_nxt  = rsp_data_q;
    rsp_unit_nxt  = rsp_unit_q;
    rsp_err_nxt   = rsp_err_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          a_nxt     = bus.req_A;
          b_nxt     = bus.req_B;
          func_nxt  = func_t'(bus.req_FUNC);
          en_nxt    = unit_onehot(unit_t'(bus.req_FUNC[3:2]));
          state_nxt = ISSUE;
        end else begin
          ready_nxt = 1'b1;
        end
      end
      ISSUE: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A flag arriving in the timeout cycle still counts as success
        if (sel_flag_c) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = sel_out_c;
          rsp_unit_nxt  = func_q.unit;
          rsp_err_nxt   = 1'b0;
          state_nxt     = RESP;
        end else begin
          cnt_inc = 1'b1;
          if (cnt_term_c) begin
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = '0;
            rsp_unit_nxt  = func_q.unit;
            rsp_err_nxt   = 1'b1;
            state_nxt     = RESP;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          ready_nxt     = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q         <= '0;
      b_q         <= '0;
      func_q      <= '0;
      en_q        <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_unit_q  <= ARITH;
      rsp_err_q   <= 1'b0;
    end else begin
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      func_q      <= func_nxt;
      en_q        <= en_nxt;
      ready_q     <= ready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_data_q  <= rsp_data_nxt;
      rsp_unit_q  <= rsp_unit_nxt;
      rsp_err_q   <= rsp_err_nxt;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ALU_FUNC  = func_q.op;
  assign bus.Arith_EN  = en_q[0];
  assign bus.Logic_EN  = en_q[1];
  assign bus.CMP_EN    = en_q[2];
  assign bus.SHIFT_EN  = en_q[3];
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_unit  = rsp_unit_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
